// File: rtl/garduino_led_sequencer.sv
// garduino_led_sequencer
// Avalon-MM slave that sequences the 8-bit greenhouse status LED bank.
// It supports static, blink and chase patterns. A programmable prescaler
// produces the pattern tick.
// Optional feature: define GRED_LEDS_ALARM_EN to add the alarm_in port
// and the sticky ALARM flag. While ALARM is set, the whole bank flashes.
module garduino_led_sequencer #(
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(2_499_999)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
`ifdef GRED_LEDS_ALARM_EN
    input  logic        alarm_in,
`endif
    output logic [7:0]  out_port
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_ON     = 2'd1;
    localparam logic [1:0] ADDR_BLINK  = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STATIC,
        ST_BLINK,
        ST_CHASE
    } state_t;

    // Bus decode
    logic wr_en;
    logic wr_ctrl;
    logic wr_on;
    logic wr_blink;
    logic wr_period;
    logic restart;

    assign wr_en     = chipselect && !write_n;
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
    assign wr_on     = wr_en && (address == ADDR_ON);
    assign wr_blink  = wr_en && (address == ADDR_BLINK);
    assign wr_period = wr_en && (address == ADDR_PERIOD);
    // Reprogramming the mode or the rate restarts the pattern from a clean start.
    assign restart   = wr_ctrl || wr_period;

    // Only part of the write word is meaningful. Fold the rest away.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Programmable registers
    logic             en_reg;
    logic [1:0]       mode_reg;
    logic [7:0]       on_reg;
    logic [7:0]       blink_reg;
    logic [CNT_W-1:0] period_reg;

    // Sequencer state
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             phase_reg;
    logic             phase_next;
    logic [2:0]       pos_reg;
    logic [2:0]       pos_next;
    logic [7:0]       out_reg;
    logic [7:0]       out_next;
    logic             en_next;
    logic [1:0]       mode_next;
    logic             run;
    logic             tick;

`ifdef GRED_LEDS_ALARM_EN
    logic alarm_s_reg;
    logic alarm_reg;
    logic alarm_set;
    logic alarm_clr;

    // Edge-detect against the single sample register. A set beats a clear.
    assign alarm_set = alarm_in && !alarm_s_reg;
    assign alarm_clr = wr_ctrl && writedata[31];

    // The alarm sample register and the sticky ALARM flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_s_reg <= 1'b0;
            alarm_reg   <= 1'b0;
        end else begin
            alarm_s_reg <= alarm_in;
            if (alarm_set) begin
                alarm_reg <= 1'b1;
            end else if (alarm_clr) begin
                alarm_reg <= 1'b0;
            end
        end
    end
`else
    logic alarm_reg;
    assign alarm_reg = 1'b0;
`endif

    // Register file updates from bus writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_reg     <= 1'b0;
            mode_reg   <= 2'b00;
            on_reg     <= 8'h00;
            blink_reg  <= 8'h00;
            period_reg <= DEFAULT_PERIOD;
        end else begin
            if (wr_ctrl) begin
                en_reg   <= writedata[0];
                mode_reg <= writedata[2:1];
            end
            if (wr_on) begin
                on_reg <= writedata[7:0];
            end
            if (wr_blink) begin
                blink_reg <= writedata[7:0];
            end
            if (wr_period) begin
                period_reg <= writedata[CNT_W-1:0];
            end
        end
    end

    // The state follows the CTRL value being written this cycle. That keeps
    // the state in step with en_reg and mode_reg, with no extra cycle of lag.
    always_comb begin
        en_next   = wr_ctrl ? writedata[0]   : en_reg;
        mode_next = wr_ctrl ? writedata[2:1] : mode_reg;
        state_next = ST_IDLE;
        if (en_next) begin
            case (mode_next)
                2'b01:   state_next = ST_BLINK;
                2'b10:   state_next = ST_CHASE;
                default: state_next = ST_STATIC;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The prescaler runs whenever a pattern is active. An alarm also keeps it running.
    assign run  = (state_reg != ST_IDLE) || alarm_reg;
    assign tick = run && (cnt_reg == period_reg);

    // Prescaler, phase and chase position. A restart has priority over a tick.
    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        pos_next   = pos_reg;
        if (restart || !run) begin
            cnt_next   = '0;
            phase_next = 1'b0;
            pos_next   = 3'd0;
        end else if (tick) begin
            cnt_next   = '0;
            phase_next = !phase_reg;
            if (state_reg == ST_CHASE) begin
                pos_next = pos_reg + 3'd1;
            end
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Pattern output for the next LED update. The alarm flash overrides every mode.
    always_comb begin
        out_next = 8'h00;
        if (alarm_reg) begin
            out_next = {8{phase_reg}};
        end else begin
            case (state_reg)
                ST_STATIC: out_next = on_reg;
                ST_BLINK:  out_next = on_reg | (blink_reg & {8{phase_reg}});
                ST_CHASE:  out_next = on_reg | (8'h01 << pos_reg);
                default:   out_next = 8'h00;
            endcase
        end
    end

    // Sequencer datapath registers, including the LED drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            pos_reg   <= 3'd0;
            out_reg   <= 8'h00;
        end else begin
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            pos_reg   <= pos_next;
            out_reg   <= out_next;
        end
    end

    assign out_port = out_reg;

    // Zero-wait-state read mux. It has no side effects.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_CTRL: begin
                readdata[0]   = en_reg;
                readdata[2:1] = mode_reg;
                readdata[8]   = phase_reg;
                readdata[9]   = alarm_reg;
            end
            ADDR_ON:    readdata[7:0] = on_reg;
            ADDR_BLINK: readdata[7:0] = blink_reg;
            default:    readdata[CNT_W-1:0] = period_reg;
        endcase
    end

endmodule

// File: doc/garduino_led_sequencer.md
# garduino_led_sequencer

Avalon-MM controlled LED sequencer that drives the 8-bit greenhouse status LED bank. The PIO output port holds a static value only. This block adds a programmable prescaler and a mode state machine that sequence the port in static, blink or chase patterns without CPU intervention. It sits on the system bus next to the other PIOs, and its `out_port` connects directly to the board LEDs.

## Interface
- `DEFAULT_PERIOD`, 24'd2_499_999: reset value of the PERIOD register, giving a tick period of DEFAULT_PERIOD+1 clocks.
- `CNT_W`, 24: width of the prescaler counter and the PERIOD register.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe; a write is `chipselect && !write_n`.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data, 0 wait states.
- `out_port` out 8: registered LED drive.
- `alarm_in` in 1: only present with GRED_LEDS_ALARM_EN; hardware alarm request.

## Operation
- Register map:
  - 0 CTRL: [0] EN, [2:1] MODE (00 static, 01 blink, 10 chase, 11 treated as static), [8] PHASE (read-only), [9] ALARM (read-only), [31] ALARM_CLR (write-only, reads 0).
  - 1 ON [7:0].
  - 2 BLINK [7:0].
  - 3 PERIOD [CNT_W-1:0].
- Unused read bits return 0.
- Register reset values: CTRL=0, ON=0, BLINK=0, PERIOD=DEFAULT_PERIOD.
- Prescaler:
  - `cnt` counts 0..PERIOD and wraps to 0.
  - `tick` asserts for one cycle when `cnt==PERIOD`.
  - PERIOD=0 gives a tick every cycle.
- State machine: IDLE, STATIC, BLINK, CHASE.
  - IDLE when EN=0. Otherwise the state is selected by MODE and re-evaluated every cycle.
  - In IDLE, `cnt`, `phase` and `pos` are held at 0.
- Restart rule: any write to CTRL or PERIOD clears `cnt`, `phase` and `pos` to 0 in the same edge as the register update.
- `phase` toggles on each tick.
- `pos` (3 bits) increments on each tick in CHASE only, wrapping 7→0.
- Next output value:
  - IDLE: 0.
  - STATIC: ON.
  - BLINK: ON | (BLINK & {8{phase}}).
  - CHASE: ON | (8'b1 << pos).
- Writes to ON or BLINK take effect on the next output update. They do not restart the counter.
- Reads have no side effects.

## Timing
- `out_port` is registered and updates 1 clock after the value it is computed from. A register write at edge N is visible on `out_port` after edge N+1.
- Reset clears `out_port`, `cnt`, `phase`, `pos` and all registers to their reset values immediately (asynchronous). Release is synchronous to the next `clk` edge.
- Reset asserted mid-sequence abandons the sequence. After release the block is in IDLE with `out_port`=0.
- Tick interval is exactly PERIOD+1 clocks.
  - Blink full cycle: 2·(PERIOD+1) clocks.
  - Chase full cycle: 8·(PERIOD+1) clocks.
- `readdata` is valid in the same cycle as `address`. It reflects register state as of the last edge.
- A write coinciding with a tick: the write/restart wins, so `phase` and `pos` go to 0.

## Configuration
- `GRED_LEDS_ALARM_EN` defined:
  - Adds the `alarm_in` port.
  - `alarm_in` is registered once. Its rising edge (registered value 0→1) sets the ALARM flag.
  - While ALARM=1:
    - `out_port` = {8{phase}}, overriding EN and MODE.
    - The prescaler runs even if EN=0.
  - Writing CTRL with bit 31=1 clears ALARM.
  - A set in the same cycle as a clear leaves ALARM=1.
  - Reset clears ALARM and the alarm sample register.
- `GRED_LEDS_ALARM_EN` undefined:
  - No `alarm_in` port.
  - CTRL[9] reads 0 and CTRL[31] is ignored.
  - Behaviour is otherwise identical.

## Test plan
- Reset check: assert `reset` mid-run with CHASE active. Required: `out_port`=0, CTRL=0 and PERIOD=DEFAULT_PERIOD immediately. Required: `out_port` stays 0 after release.
- Static mode: write ON=0xA5, then CTRL=0x1. Required: `out_port`=0xA5 one clock after the CTRL write. Required: readback addr1=0x000000A5.
- Blink mode: write PERIOD=3, ON=0x01, BLINK=0xF0, CTRL=0x3.
  - Required: `out_port` alternates 0x01 / 0xF1 every 4 clocks.
  - Required: CTRL[8] tracks `phase`.
- Chase wrap: write PERIOD=0, ON=0, CTRL=0x5. Required: `out_port` steps 0x01, 0x02 … 0x80, then 0x01, one step per clock.
- Restart: write PERIOD=9 while in BLINK mid-period. Required: the first toggle occurs exactly 10 clocks after the write edge.
- Alarm (macro on): pulse `alarm_in` with EN=0 and PERIOD=1.
  - Required: ALARM=1 and `out_port` toggling 0x00 / 0xFF every 2 clocks.
  - Write CTRL=0x8000_0000. Required: ALARM=0 and `out_port`=0.
